sdram_rw_checker: RTL and testbench

//  Self-test traffic source/sink on the user side of the SDRAM FIFO port controller.

---
 rtl/sdram_chk_pkg.sv | 30 +++
 rtl/sdram_pattern_gen.sv | 65 ++++++
 rtl/sdram_rw_checker.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_rw_checker.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_chk_pkg.sv
// -----------------------------------------------------------------------------
// sdram_chk_pkg
//   Shared constants for the SDRAM read/write self-test checker:
//     - FSM state encoding (3-bit, legacy-compatible localparams)
//     - 16-bit Fibonacci LFSR seed, tap mask and single-step helper
//     - WAIT_FILL: idle cycles in READ before the first read request, giving
//       the FIFO controller time to refill the read FIFO from SDRAM
// -----------------------------------------------------------------------------
package sdram_chk_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form:
  // the feedback bit is the XOR of state bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int WAIT_FILL = 64;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// -----------------------------------------------------------------------------
// sdram_pattern_gen
//   Deterministic test-pattern source. One instance generates write data, a
//   second instance reproduces the same sequence to check read data.
//   Build option SDRAM_CHK_LFSR_EN:
//     defined   : 16-bit Fibonacci LFSR from LFSR_SEED, replicated across
//                 DATA_W when DATA_W > 16
//     undefined : incrementing count, first word 1 (word k = k+1)
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (returns to seed)
//   clr    in   synchronous return to seed
//   adv    in   step to the next word after this cycle
//   word   out  current pattern word (DATA_W)
// -----------------------------------------------------------------------------
module sdram_pattern_gen
  import sdram_chk_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [DATA_W-1:0] word
);

`ifdef SDRAM_CHK_LFSR_EN
  logic [15:0] r_lfsr;

  // NOTE: clocked state is always assigned with <= so every register in the
  // design samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (clr) begin
      r_lfsr <= LFSR_SEED;
    end else if (adv) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  // Wider words repeat the 16-bit state; bit i comes from LFSR bit i mod 16.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rep
    assign word[gi] = r_lfsr[gi % 16];
  end
`else
  logic [DATA_W-1:0] r_cnt;

  // NOTE: clocked state is always assigned with <= so every register in the
  // design samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= DATA_W'(1);
    end else if (clr) begin
      r_cnt <= DATA_W'(1);
    end else if (adv) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign word = r_cnt;
`endif

endmodule

// File: rtl/sdram_rw_checker.sv
// -----------------------------------------------------------------------------
// sdram_rw_checker
//   Self-test traffic source/sink on the user side of the SDRAM FIFO port
//   controller. After SDRAM init it pulses the FIFO port resets, writes
//   TEST_LEN pattern words, waits READ_DELAY cycles for the write FIFO to
//   drain, enables SDRAM reads, then reads TEST_LEN words back and compares
//   them with the same pattern. Reports done, sticky error and error count.
//   Build option SDRAM_CHK_LFSR_EN selects an LFSR pattern instead of a count.
// Ports
//   clk               in   single clock (also clocks the FIFO controller ports)
//   rst_n             in   asynchronous active-low reset
//   sdram_init_done   in   SDRAM initialisation complete; low mid-run aborts
//   test_start        in   rising edge re-runs the test from DONE
//   wrf_wrreq         out  write-FIFO write request
//   wrf_din           out  write-FIFO data (0 when not writing)
//   wr_load           out  write-port reset pulse
//   rd_load           out  read-port reset pulse
//   sdram_read_valid  out  enables SDRAM -> read-FIFO refills
//   rdf_rdreq         out  read-FIFO read request
//   rdf_dout          in   read-FIFO data, valid one cycle after rdf_rdreq
//   test_done         out  high in DONE
//   error_flag        out  sticky mismatch flag for the current run
//   err_cnt           out  mismatch count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module sdram_rw_checker
  import sdram_chk_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int TEST_LEN   = 1024,
  parameter int LOAD_CYC   = 4,
  parameter int READ_DELAY = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic              test_start,
  output logic              wrf_wrreq,
  output logic [DATA_W-1:0] wrf_din,
  output logic              wr_load,
  output logic              rd_load,
  output logic              sdram_read_valid,
  output logic              rdf_rdreq,
  input  logic [DATA_W-1:0] rdf_dout,
  output logic              test_done,
  output logic              error_flag,
  output logic [15:0]       err_cnt
);

  // The delay counter also times the WAIT_FILL gap at the start of READ.
  localparam int DLY_MAX = (LOAD_CYC > READ_DELAY)
                         ? ((LOAD_CYC > WAIT_FILL) ? LOAD_CYC : WAIT_FILL)
                         : ((READ_DELAY > WAIT_FILL) ? READ_DELAY : WAIT_FILL);
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int IDX_W   = $clog2(TEST_LEN + 1);

  logic [2:0]        r_state;
  logic [DLY_W-1:0]  r_dly_cnt;
  logic [IDX_W-1:0]  r_word_cnt;
  logic              r_start_q;
  logic              r_rd_vld;
  logic              r_error_flag;
  logic [15:0]       r_err_cnt;

  logic              w_abort;
  logic              w_start_rise;
  logic              w_fill_done;
  logic              w_pat_clr;
  logic [DATA_W-1:0] w_gen_word;
  logic [DATA_W-1:0] w_chk_word;

  // Losing init mid-run drops straight back to IDLE; IDLE and DONE are the
  // only states where the SDRAM side is not being exercised.
  assign w_abort      = !sdram_init_done && (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_start_rise = test_start && !r_start_q;
  assign w_fill_done  = (r_dly_cnt == DLY_W'(WAIT_FILL));
  assign w_pat_clr    = (r_state == ST_LOAD);

  // NOTE: outputs are continuous assigns decoded from registered state, so
  // every output has a value on every path and no latch can be inferred.
  assign wr_load          = (r_state == ST_LOAD);
  assign rd_load          = (r_state == ST_LOAD);
  assign wrf_wrreq        = (r_state == ST_WRITE);
  assign wrf_din          = wrf_wrreq ? w_gen_word : '0;
  assign sdram_read_valid = (r_state == ST_READ) || (r_state == ST_CHECK);
  assign rdf_rdreq        = (r_state == ST_READ) && w_fill_done;
  assign test_done        = (r_state == ST_DONE);
  assign error_flag       = r_error_flag;
  assign err_cnt          = r_err_cnt;

  sdram_pattern_gen #(.DATA_W(DATA_W)) u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_pat_clr),
    .adv   (wrf_wrreq),
    .word  (w_gen_word)
  );

  sdram_pattern_gen #(.DATA_W(DATA_W)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_pat_clr),
    .adv   (r_rd_vld),
    .word  (w_chk_word)
  );

  // Sequencer: LOAD and WAIT are timed by r_dly_cnt; WRITE and the request
  // phase of READ are timed by r_word_cnt. READ first spends WAIT_FILL idle
  // cycles on r_dly_cnt, then issues TEST_LEN read requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dly_cnt  <= '0;
      r_word_cnt <= '0;
      r_start_q  <= 1'b0;
    end else begin
      r_start_q <= test_start;
      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_dly_cnt  <= '0;
        r_word_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (sdram_init_done) begin
              r_state   <= ST_LOAD;
              r_dly_cnt <= '0;
            end
          end
          ST_LOAD: begin
            if (r_dly_cnt == DLY_W'(LOAD_CYC - 1)) begin
              r_state    <= ST_WRITE;
              r_dly_cnt  <= '0;
              r_word_cnt <= '0;
            end else begin
              r_dly_cnt <= r_dly_cnt + 1'b1;
            end
          end
          ST_WRITE: begin
            if (r_word_cnt == IDX_W'(TEST_LEN - 1)) begin
              r_state    <= ST_WAIT;
              r_word_cnt <= '0;
              r_dly_cnt  <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (r_dly_cnt == DLY_W'(READ_DELAY - 1)) begin
              r_state   <= ST_READ;
              r_dly_cnt <= '0;
            end else begin
              r_dly_cnt <= r_dly_cnt + 1'b1;
            end
          end
          ST_READ: begin
            if (!w_fill_done) begin
              r_dly_cnt <= r_dly_cnt + 1'b1;
            end else if (r_word_cnt == IDX_W'(TEST_LEN - 1)) begin
              r_state    <= ST_CHECK;
              r_word_cnt <= '0;
              r_dly_cnt  <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            r_state <= ST_DONE;
          end
          ST_DONE: begin
            if (w_start_rise) begin
              r_state    <= ST_LOAD;
              r_dly_cnt  <= '0;
              r_word_cnt <= '0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Compare pipeline: read data arrives one cycle after the request, so the
  // request is delayed by one flop and the checker pattern advances on it.
  // An abort cancels the in-flight compare so no partial-run result lands
  // after the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld     <= 1'b0;
      r_error_flag <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_rd_vld <= rdf_rdreq && !w_abort;
      if (r_state == ST_LOAD) begin
        r_error_flag <= 1'b0;
        r_err_cnt    <= '0;
      end else if (r_rd_vld && (rdf_dout != w_chk_word)) begin
        r_error_flag <= 1'b1;
        if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_rw_checker.sv
// -----------------------------------------------------------------------------
// tb_sdram_rw_checker
//   Self-checking bench for sdram_rw_checker with a behavioural FIFO
//   controller + SDRAM memory model. Expected write words are queued from a
//   golden pattern model before each run and popped as the DUT writes;
//   end-of-run status is compared against per-scenario expectations.
// -----------------------------------------------------------------------------
module tb_sdram_rw_checker;

  localparam int DATA_W     = 16;
  localparam int TEST_LEN   = 16;
  localparam int LOAD_CYC   = 4;
  localparam int READ_DELAY = 20;
  localparam int MAX_CYC    = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sdram_init_done = 1'b0;
  logic              test_start = 1'b0;
  logic              wrf_wrreq;
  logic [DATA_W-1:0] wrf_din;
  logic              wr_load;
  logic              rd_load;
  logic              sdram_read_valid;
  logic              rdf_rdreq;
  logic [DATA_W-1:0] rdf_dout = '0;
  logic              test_done;
  logic              error_flag;
  logic [15:0]       err_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] first_w[3];

  // Memory model controls.
  logic [15:0] mem [0:63];
  int          wptr = 0;
  int          rptr = 0;
  int          corrupt_idx = -1;
  bit          zero_mode = 1'b0;

  sdram_rw_checker #(
    .DATA_W     (DATA_W),
    .TEST_LEN   (TEST_LEN),
    .LOAD_CYC   (LOAD_CYC),
    .READ_DELAY (READ_DELAY)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sdram_init_done  (sdram_init_done),
    .test_start       (test_start),
    .wrf_wrreq        (wrf_wrreq),
    .wrf_din          (wrf_din),
    .wr_load          (wr_load),
    .rd_load          (rd_load),
    .sdram_read_valid (sdram_read_valid),
    .rdf_rdreq        (rdf_rdreq),
    .rdf_dout         (rdf_dout),
    .test_done        (test_done),
    .error_flag       (error_flag),
    .err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO controller + SDRAM: sequential store, registered read.
  always @(posedge clk) begin
    if (wr_load) begin
      wptr <= 0;
    end else if (wrf_wrreq) begin
      mem[wptr[5:0]] <= wrf_din;
      wptr <= wptr + 1;
    end
    if (rd_load) begin
      rptr <= 0;
    end else if (rdf_rdreq && sdram_read_valid) begin
      if (zero_mode)              rdf_dout <= 16'h0000;
      else if (rptr == corrupt_idx) rdf_dout <= mem[rptr[5:0]] ^ 16'h0001;
      else                        rdf_dout <= mem[rptr[5:0]];
      rptr <= rptr + 1;
    end
  end

  // Golden pattern: word k of a run.
  function automatic logic [15:0] golden(input int k);
`ifdef SDRAM_CHK_LFSR_EN
    logic [15:0] s;
    logic        b;
    s = 16'hACE1;
    for (int i = 0; i < k; i++) begin
      b = s[0] ^ s[2] ^ s[3] ^ s[5];
      s = {b, s[15:1]};
    end
    return s;
`else
    return 16'(k + 1);
`endif
  endfunction

  // One run: kick (0 none, 1 test_start pulse, 2 raise init_done, 3 release
  // reset), then monitor until test_done. Optional mid-WAIT test_start pulse,
  // mid-WAIT error-count preload, or abort after N written words.
  task automatic run_test(input string name, input int kick, input bit mid_start,
                          input bit force_sat, input int abort_after,
                          input logic [15:0] exp_cnt, input logic exp_flag);
    int          load_cnt = 0;
    int          rld_cnt  = 0;
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    int          cyc      = 0;
    bit          done     = 1'b0;
    bit          waited   = 1'b0;
    bit          forced   = 1'b0;
    logic [15:0] exp_w;
    logic [16:0] prev_stat;
    exp_q.delete();
    for (int k = 0; k < TEST_LEN; k++) exp_q.push_back(golden(k));
    @(negedge clk);
    case (kick)
      1: test_start = 1'b1;
      2: sdram_init_done = 1'b1;
      3: rst_n = 1'b1;
      default: ;
    endcase
    while (!done && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      test_start = 1'b0;
      if (forced) begin
        release dut.r_err_cnt;
        forced = 1'b0;
      end
      if (wr_load) begin
        load_cnt++;
        if (load_cnt == LOAD_CYC) begin
          n_chk++;
          if ({error_flag, err_cnt} !== 17'h0) begin
            n_err++;
            $display("FAIL %s load_clear: got flag=%b cnt=%h expected flag=0 cnt=0000", name, error_flag, err_cnt);
          end
        end
      end
      if (rd_load) rld_cnt++;
      if (wrf_wrreq) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s wr_extra: got write %h expected no write", name, wrf_din);
        end else begin
          exp_w = exp_q.pop_front();
          if (wrf_din !== exp_w) begin
            n_err++;
            $display("FAIL %s wr_data[%0d]: got %h expected %h", name, wr_cnt, wrf_din, exp_w);
          end
        end
        if (wr_cnt < 3) first_w[wr_cnt] = wrf_din;
        wr_cnt++;
        if (abort_after != 0 && wr_cnt == abort_after) begin
          prev_stat = {error_flag, err_cnt};
          sdram_init_done = 1'b0;
          @(negedge clk);
          n_chk++;
          if ({wrf_wrreq, wr_load, rd_load, rdf_rdreq, sdram_read_valid, test_done} !== 6'b0) begin
            n_err++;
            $display("FAIL %s abort_outputs: got %b expected 000000", name,
                     {wrf_wrreq, wr_load, rd_load, rdf_rdreq, sdram_read_valid, test_done});
          end
          n_chk++;
          if ({error_flag, err_cnt} !== prev_stat) begin
            n_err++;
            $display("FAIL %s abort_status: got %h expected %h", name, {error_flag, err_cnt}, prev_stat);
          end
          @(negedge clk);
          n_chk++;
          if (wrf_wrreq !== 1'b0 || wr_load !== 1'b0) begin
            n_err++;
            $display("FAIL %s abort_idle: got wrreq=%b load=%b expected 0 0", name, wrf_wrreq, wr_load);
          end
          exp_q.delete();
          return;
        end
      end
      if (!wrf_wrreq && wr_cnt == TEST_LEN && !waited) begin
        waited = 1'b1;
        if (mid_start) test_start = 1'b1;
        if (force_sat) begin
          force dut.r_err_cnt = 16'hFFFC;
          forced = 1'b1;
        end
      end
      if (rdf_rdreq) begin
        rd_cnt++;
        n_chk++;
        if (sdram_read_valid !== 1'b1) begin
          n_err++;
          $display("FAIL %s rd_valid: got %b expected 1", name, sdram_read_valid);
        end
      end
      if (test_done) done = 1'b1;
    end
    n_chk++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: got no test_done expected done within %0d cycles", name, MAX_CYC);
    end
    n_chk++;
    if (load_cnt != LOAD_CYC || rld_cnt != LOAD_CYC) begin
      n_err++;
      $display("FAIL %s load_len: got wr=%0d rd=%0d expected %0d", name, load_cnt, rld_cnt, LOAD_CYC);
    end
    n_chk++;
    if (wr_cnt != TEST_LEN || rd_cnt != TEST_LEN || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s xfer_len: got wr=%0d rd=%0d left=%0d expected %0d %0d 0", name,
               wr_cnt, rd_cnt, exp_q.size(), TEST_LEN, TEST_LEN);
    end
    n_chk++;
    if (error_flag !== exp_flag) begin
      n_err++;
      $display("FAIL %s error_flag: got %b expected %b", name, error_flag, exp_flag);
    end
    n_chk++;
    if (err_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL %s err_cnt: got %h expected %h", name, err_cnt, exp_cnt);
    end
    n_chk++;
    if ({sdram_read_valid, rdf_rdreq, wrf_wrreq} !== 3'b000) begin
      n_err++;
      $display("FAIL %s done_idle: got %b expected 000", name, {sdram_read_valid, rdf_rdreq, wrf_wrreq});
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({wrf_wrreq, wr_load, rd_load, sdram_read_valid, rdf_rdreq, test_done, error_flag} !== 7'b0
        || wrf_din !== '0 || err_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b din=%h cnt=%h expected all zero",
               {wrf_wrreq, wr_load, rd_load, sdram_read_valid, rdf_rdreq, test_done, error_flag}, wrf_din, err_cnt);
    end
    rst_n = 1'b1;
    // Cycles 1..9 after reset with init low: must stay idle.
    for (int i = 0; i < 9; i++) @(negedge clk);
    n_chk++;
    if ({wrf_wrreq, wr_load, rd_load, sdram_read_valid, test_done} !== 5'b0) begin
      n_err++;
      $display("FAIL idle_hold: got %b expected 00000",
               {wrf_wrreq, wr_load, rd_load, sdram_read_valid, test_done});
    end
  endtask

  task automatic test_clean_run;
    logic [15:0] ref_w[3];
`ifdef SDRAM_CHK_LFSR_EN
    ref_w[0] = 16'hACE1; ref_w[1] = 16'h5670; ref_w[2] = 16'hAB38;
`else
    ref_w[0] = 16'h0001; ref_w[1] = 16'h0002; ref_w[2] = 16'h0003;
`endif
    run_test("clean", 2, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (first_w[i] !== ref_w[i]) begin
        n_err++;
        $display("FAIL first_word[%0d]: got %h expected %h", i, first_w[i], ref_w[i]);
      end
    end
  endtask

  task automatic test_corrupt_word;
    corrupt_idx = 5;
    run_test("corrupt", 1, 1'b0, 1'b0, 0, 16'h0001, 1'b1);
    corrupt_idx = -1;
  endtask

  // Starts from err_cnt=1; LOAD must clear it. A test_start pulse in WAIT
  // must be ignored (checked via exactly one LOAD phase).
  task automatic test_start_clears;
    run_test("restart", 1, 1'b1, 1'b0, 0, 16'h0000, 1'b0);
  endtask

  task automatic test_all_zero;
    zero_mode = 1'b1;
    run_test("zeros", 1, 1'b0, 1'b0, 0, 16'd16, 1'b1);
  endtask

  task automatic test_saturation;
    run_test("saturate", 1, 1'b0, 1'b1, 0, 16'hFFFF, 1'b1);
    zero_mode = 1'b0;
  endtask

  task automatic test_abort;
    run_test("abort", 1, 1'b0, 1'b0, 7, 16'h0000, 1'b0);
    run_test("abort_rerun", 2, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
  endtask

  task automatic test_async_reset;
    int seen = 0;
    int cyc  = 0;
    @(negedge clk);
    test_start = 1'b1;
    @(negedge clk);
    test_start = 1'b0;
    while (seen < 3 && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      if (wrf_wrreq) seen++;
    end
    n_chk++;
    if (seen < 3) begin
      n_err++;
      $display("FAIL async_setup: got %0d writes expected 3", seen);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({wrf_wrreq, wr_load, sdram_read_valid, test_done, error_flag} !== 5'b0 || wrf_din !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %b din=%h expected zero",
               {wrf_wrreq, wr_load, sdram_read_valid, test_done, error_flag}, wrf_din);
    end
    @(negedge clk);
    run_test("async_rerun", 3, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_corrupt_word();
    test_start_clears();
    test_all_zero();
    test_saturation();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
